// File: rtl/ring_buffer_param.sv
// Parametrised single-clock circular FIFO with registered read data, status flags,
// occupancy count, overflow/underflow pulses and optional overwrite-on-full.
module ring_buffer_param #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int OVERWRITE = 0,
  parameter int AF_LEVEL  = DEPTH - 2,
  parameter int AE_LEVEL  = 2
) (
  input  logic                       clock_i,
  input  logic                       reset_i,
  input  logic                       enable_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           datain_i,
  output logic [WIDTH-1:0]           dataout_o,
  output logic                       valid_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic                       almost_full_o,
  output logic                       almost_empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       overflow_o,
  output logic                       underflow_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             vld_q, vld_d, ovf_q, ovf_d, udf_q, udf_d;
  logic             full_q, empty_q, af_q, ae_q;

  logic is_full, is_empty, pop_ok, push_ok, ovw, wr_en;

  always_comb begin
    is_full  = (cnt_q == DEPTH_C);
    is_empty = (cnt_q == '0);
    pop_ok   = enable_i & pop_i & ~is_empty;
    // a pop in the same cycle frees a slot, so a full buffer still accepts the push
    push_ok  = enable_i & push_i & (~is_full | pop_ok);
    ovw      = (OVERWRITE != 0) & enable_i & push_i & is_full & ~pop_ok;
    wr_en    = (push_ok | ovw) & ~reset_i;
  end

  always_comb begin
    wr_d   = wr_q;
    rd_d   = rd_q;
    cnt_d  = cnt_q;
    dout_d = dout_q;
    vld_d  = pop_ok;
    ovf_d  = enable_i & push_i & is_full & ~pop_ok;
    udf_d  = enable_i & pop_i & is_empty;
    if (pop_ok) begin
      dout_d = mem[rd_q];
      rd_d   = rd_q + AW'(1);
    end
    if (push_ok | ovw) wr_d = wr_q + AW'(1);
    // overwrite drops the oldest entry by stepping the read side past it
    if (ovw) rd_d = rd_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (wr_en) mem[wr_q] <= datain_i;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      vld_q   <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      vld_q   <= vld_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
      full_q  <= (cnt_d == DEPTH_C);
      empty_q <= (cnt_d == '0);
      af_q    <= (32'(cnt_d) >= AF_LEVEL);
      ae_q    <= (32'(cnt_d) <= AE_LEVEL);
    end
  end

  assign dataout_o      = dout_q;
  assign valid_o        = vld_q;
  assign full_o         = full_q;
  assign empty_o        = empty_q;
  assign almost_full_o  = af_q;
  assign almost_empty_o = ae_q;
  assign count_o        = cnt_q;
  assign overflow_o     = ovf_q;
  assign underflow_o    = udf_q;

endmodule
